// File: rtl/bk_multiword_add_seq.sv
// -----------------------------------------------------------------------------
// bk_multiword_add_seq
//
// Purpose:
//   Sequences a WORDS*WIDTH-bit addition through one external WIDTH-bit
//   combinational parallel-prefix adder. Each request is processed one chunk
//   per cycle, least-significant chunk first. The adder carry-out of one chunk
//   becomes the carry-in of the next. The block sits between a valid/ready
//   producer (operands) and a valid/ready consumer (result).
//
// Optional feature (compile-time macro BK_SEQ_SUB_EN):
//   When defined, an extra 1-bit input `sub` is latched at accept. With sub=1
//   the block computes A-B as A + ~B + 1, and cin is ignored. In that mode
//   cout=1 means no borrow (A >= B unsigned). When the macro is undefined
//   there is no `sub` port and the result is always A+B+cin.
//
// Ports:
//   clk        in   1            clock, rising edge
//   rst_n      in   1            asynchronous active-low reset
//   in_valid   in   1            operand request valid
//   in_ready   out  1            high in IDLE; request accepted on valid&&ready
//   op_a       in   WORDS*WIDTH  operand A
//   op_b       in   WORDS*WIDTH  operand B
//   cin        in   1            initial carry-in
//   sub        in   1            (BK_SEQ_SUB_EN only) subtract request
//   out_valid  out  1            result valid
//   out_ready  in   1            consumer accepts result on valid&&ready
//   sum        out  WORDS*WIDTH  result (previous value held while invalid)
//   cout       out  1            final carry-out
//   add_a      out  WIDTH        chunk of A to external adder
//   add_b      out  WIDTH        chunk of B (inverted when subtracting)
//   add_cin    out  1            carry to external adder
//   add_s      in   WIDTH        adder sum, same-cycle combinational return
//   add_cout   in   1            adder carry-out
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bk_multiword_add_seq #(
    parameter int WIDTH = 16,
    parameter int WORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORDS*WIDTH-1:0] op_a,
    input  logic [WORDS*WIDTH-1:0] op_b,
    input  logic                   cin,
`ifdef BK_SEQ_SUB_EN
    input  logic                   sub,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WORDS*WIDTH-1:0] sum,
    output logic                   cout,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_cout
);

    localparam int IDXW  = $clog2(WORDS);
    localparam int TOT_W = WORDS * WIDTH;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [IDXW-1:0]   r_idx;
    logic              r_carry;
    logic              r_sub;
    logic [TOT_W-1:0]  r_op_a;
    logic [TOT_W-1:0]  r_op_b;
    logic [TOT_W-1:0]  r_sum;
    logic              r_cout;
    logic              r_out_valid;

    logic              w_sub_in;
    logic              w_last;
    logic [WIDTH-1:0]  w_chunk_a;
    logic [WIDTH-1:0]  w_chunk_b;

    // Without the subtract feature the mode bit is tied off; the latched copy
    // then stays constant and folds away in synthesis.
`ifdef BK_SEQ_SUB_EN
    assign w_sub_in = sub;
`else
    assign w_sub_in = 1'b0;
`endif

    assign w_last    = (r_idx == IDXW'(WORDS - 1));
    assign w_chunk_a = r_op_a[int'(r_idx) * WIDTH +: WIDTH];
    assign w_chunk_b = r_op_b[int'(r_idx) * WIDTH +: WIDTH];

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;

    // The adder is only fed while a chunk is being processed; otherwise its
    // inputs are parked at zero so it does not toggle between operations.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (r_state == S_RUN) begin
            add_a   = w_chunk_a;
            add_b   = r_sub ? ~w_chunk_b : w_chunk_b;
            add_cin = r_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_sub       <= 1'b0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        r_op_a  <= op_a;
                        r_op_b  <= op_b;
                        r_sub   <= w_sub_in;
                        // Subtraction is A + ~B + 1, so the chain starts with
                        // a forced carry and the caller's cin is ignored.
                        r_carry <= w_sub_in ? 1'b1 : cin;
                        r_idx   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_sum[int'(r_idx) * WIDTH +: WIDTH] <= add_s;
                    r_carry <= add_cout;
                    if (w_last) begin
                        r_cout      <= add_cout;
                        r_out_valid <= 1'b1;
                        r_idx       <= '0;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                S_DONE: begin
                    // Result registers are untouched here, so sum/cout stay
                    // stable for as long as the consumer stalls.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_idx       <= '0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// -----------------------------------------------------------------------------
// tb_bk_multiword_add_seq
//
// Self-checking bench for bk_multiword_add_seq with WIDTH=16, WORDS=4.
// The external adder is modelled here as a plain 16-bit add. Expected results
// come from 64-bit arithmetic on the whole operands (A+B+cin, or A-B with the
// borrow flag when BK_SEQ_SUB_EN is defined).
// Inputs are driven 1 ns after the rising edge, and outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bk_multiword_add_seq;

    localparam int WIDTH = 16;
    localparam int WORDS = 4;

    typedef struct {
        logic [63:0] s;
        logic        c;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        c;
        logic        sb;
        int          stall;
        logic [63:0] es;
        logic        ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        cin = 1'b0;
    logic        sub_r = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        cout;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_s;
    logic        add_cout;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   n_res = 0;
    logic sb_en = 1'b0;
    res_t exp_q[$];
    int   acc_cyc[$];

    bk_multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef BK_SEQ_SUB_EN
        .sub       (sub_r),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout)
    );

    // External combinational adder slice.
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic c, input logic sb);
        res_t        r;
        logic [64:0] t;
        if (sb) begin
            r.s = a - b;
            r.c = (a >= b);
        end else begin
            t   = {1'b0, a} + {1'b0, b} + {64'd0, c};
            r.s = t[63:0];
            r.c = t[64];
        end
        return r;
    endfunction

    // Carry entering each 16-bit chunk, from the sum of the lower bits.
    function automatic logic [3:0] chunk_carries(input logic [63:0] a, input logic [63:0] b,
                                                 input logic c, input logic sb);
        logic [64:0] t;
        logic [63:0] bb;
        logic [63:0] m;
        logic        ci;
        logic [3:0]  r;
        bb   = sb ? ~b : b;
        ci   = sb ? 1'b1 : c;
        r[0] = ci;
        for (int k = 1; k < 4; k++) begin
            m    = (64'd1 << (16 * k)) - 64'd1;
            t    = {1'b0, a & m} + {1'b0, bb & m} + {64'd0, ci};
            r[k] = t[16 * k];
        end
        return r;
    endfunction

    function automatic vec_t mkv(input logic [63:0] a, input logic [63:0] b, input logic c,
                                 input logic sb, input int stall,
                                 input logic [63:0] es, input logic ec);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.sb = sb; v.stall = stall; v.es = es; v.ec = ec;
        return v;
    endfunction

    function automatic logic [63:0] rand64();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0: r = '1;
            1: r = '0;
            2: r = 64'h8000_0000_0000_0000;
            default: ;
        endcase
        return r;
    endfunction

    // Scoreboard: an expected result is pushed at each accept handshake and
    // popped at each result handshake.
    always @(negedge clk) begin
        res_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else if (sb_en) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(model(op_a, op_b, cin, sub_r));
                acc_cyc.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    chk("sb_extra_result", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_sum", sum, e.s);
                    chk("sb_cout", 64'(cout), 64'(e.c));
                end
            end
        end
    end

    // One directed operation: called and returning 1 ns after a rising edge.
    task automatic run_op(input vec_t v, input string nm);
        int          n;
        int          lat;
        logic [3:0]  cins;
        logic [63:0] held_s;
        logic        held_c;
        op_a = v.a; op_b = v.b; cin = v.c; sub_r = v.sb;
        in_valid = 1'b1; out_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_accept"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        lat = 0;
        cins = '0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) cins[lat] = add_cin;
            @(negedge clk);
            lat++;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd4);
        chk({nm, "_chunk_cin"}, 64'(cins), 64'(chunk_carries(v.a, v.b, v.c, v.sb)));
        held_s = sum;
        held_c = cout;
        for (int i = 0; i < v.stall; i++) begin
            chk({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
            chk({nm, "_stall_ready"}, 64'(in_ready), 64'd0);
            chk({nm, "_stall_sum"}, sum, held_s);
            chk({nm, "_stall_cout"}, 64'(cout), 64'(held_c));
            @(negedge clk);
        end
        chk({nm, "_sum"}, sum, v.es);
        chk({nm, "_cout"}, 64'(cout), 64'(v.ec));
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_valid_drop"}, 64'(out_valid), 64'd0);
        chk({nm, "_ready_back"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[$];
        int   n_acc;
        int   guard;
        logic fire;
        res_t e;

        vecs.push_back(mkv(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 0,
                           64'h0000_0000_0000_0000, 1'b1));
        vecs.push_back(mkv(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0, 5,
                           64'h2222_2222_2222_2212, 1'b0));
        vecs.push_back(mkv(64'h0, 64'h0, 1'b0, 1'b0, 1, 64'h0, 1'b0));
        vecs.push_back(mkv(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 0,
                           64'hFFFF_FFFF_FFFF_FFFF, 1'b1));
        vecs.push_back(mkv(64'h0000_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 2,
                           64'h0001_0000_0000_0000, 1'b0));
        vecs.push_back(mkv(64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 0,
                           64'h8000_0000_0000_0000, 1'b0));
`ifdef BK_SEQ_SUB_EN
        vecs.push_back(mkv(64'd5, 64'd7, 1'b0, 1'b1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0));
        vecs.push_back(mkv(64'd7, 64'd5, 1'b0, 1'b1, 1, 64'd2, 1'b1));
        vecs.push_back(mkv(64'h1_0000, 64'h1, 1'b1, 1'b1, 0, 64'hFFFF, 1'b1));
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_add_a", 64'(add_a), 64'd0);
        chk("rst_add_b", 64'(add_b), 64'd0);
        chk("rst_add_cin", 64'(add_cin), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Table-driven directed vectors
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back accepts with in_valid held high
        sb_en = 1'b1;
        acc_cyc.delete();
        n_res = 0;
        out_ready = 1'b1;
        op_a = rand64(); op_b = rand64(); cin = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        n_acc = 0;
        guard = 0;
        while (n_acc < 3 && guard < 100) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                n_acc++;
                op_a = rand64(); op_b = rand64(); cin = 1'($urandom_range(0, 1));
            end
        end
        in_valid = 1'b0;
        guard = 0;
        while (n_res < 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        sb_en = 1'b0;
        chk("b2b_results", 64'(n_res), 64'd3);
        chk("b2b_accepts", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            chk("b2b_gap1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
            chk("b2b_gap2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
        end
        out_ready = 1'b0;

        // Reset in the middle of an operation (chunk index 2)
        op_a = 64'h1111_2222_3333_4444; op_b = 64'h0101_0101_0101_0101; cin = 1'b0; sub_r = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        chk("mid_accept", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_add_a_idx2", 64'(add_a), 64'h2222);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_sum", sum, 64'd0);
        chk("mid_rst_cout", 64'(cout), 64'd0);
        chk("mid_rst_add_a", 64'(add_a), 64'd0);
        chk("mid_rst_add_cin", 64'(add_cin), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(mkv(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 0,
                   64'h0, 1'b1), "post_rst");

        // Random traffic with producer and consumer stalls
        sb_en = 1'b1;
        n_res = 0;
        n_acc = 0;
        guard = 0;
        while (n_acc < 2000 && guard < 60000) begin
            @(negedge clk);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            guard++;
            if (fire) begin
                n_acc++;
                in_valid = 1'b0;
            end
            if (!in_valid && n_acc < 2000 && $urandom_range(0, 1) == 1) begin
                op_a = rand64(); op_b = rand64(); cin = 1'($urandom_range(0, 1));
`ifdef BK_SEQ_SUB_EN
                sub_r = 1'($urandom_range(0, 1));
`endif
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while (n_res < n_acc && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (10) @(negedge clk);
        sb_en = 1'b0;
        chk("rand_accepts", 64'(n_acc), 64'd2000);
        chk("rand_results", 64'(n_res), 64'(n_acc));
        chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
